// File: rtl/line_buf_1bit_ctrl.sv
// rtl/line_buf_1bit_ctrl.sv - cascade controller for two 1-bit line FIFOs forming a 3-row window
module line_buf_1bit_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             pix_vld,
  input  logic             pix_in,
  output logic             fifo0_wr_en,
  output logic             fifo0_wr_data,
  output logic             fifo0_rd_en,
  input  logic             fifo0_rd_data,
  input  logic             fifo0_full,
  input  logic             fifo0_empty,
  output logic             fifo1_wr_en,
  output logic             fifo1_wr_data,
  output logic             fifo1_rd_en,
  input  logic             fifo1_rd_data,
  input  logic             fifo1_full,
  input  logic             fifo1_empty,
  output logic             win_vld,
  output logic             tap0,
  output logic             tap1,
  output logic             tap2,
  output logic [CNT_W-1:0] col_cnt,
  output logic [CNT_W-1:0] line_cnt,
  output logic             busy,
  output logic             err_ovf,
  output logic             err_udf,
  output logic             err_abort
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL0,
    S_FILL1,
    S_STREAM,
    S_FLUSH
  } state_t;

  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(IMG_H - 1);

  state_t state, state_nxt;
  logic   wr_pend;     // FIFO0 was read for forwarding last cycle; its data goes to FIFO1 now
  logic   start_pend;  // a frame_start is waiting for the flush to finish
  logic   win_vld_q;
  logic   tap0_q, tap1_q, tap2_q;
  logic   wr0, rd0, rd1;
  logic   active, abort, take, col_wrap, flush_done, stream_take, fwd;

  assign active      = (state == S_FILL0) || (state == S_FILL1) || (state == S_STREAM);
  assign abort       = active && frame_start;
  // The pixel arriving with an abort is dropped
  assign take        = active && pix_vld && !frame_start;
  assign col_wrap    = take && (col_cnt == COL_LAST);
  assign flush_done  = fifo0_empty && fifo1_empty && !wr_pend;
  assign stream_take = take && (state == S_STREAM);
  assign fwd         = rd0 && (state != S_FLUSH);

  // Next-state and FIFO enable decode
  always_comb begin
    state_nxt = state;
    wr0       = 1'b0;
    rd0       = 1'b0;
    rd1       = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_nxt = S_FILL0;
          wr0       = pix_vld;
        end
      end
      S_FILL0: begin
        wr0 = take;
        if (abort)         state_nxt = S_FLUSH;
        else if (col_wrap) state_nxt = S_FILL1;
      end
      S_FILL1: begin
        wr0 = take;
        rd0 = take;
        if (abort)         state_nxt = S_FLUSH;
        else if (col_wrap) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        wr0 = take;
        rd0 = take;
        rd1 = take;
        if (abort)                                   state_nxt = S_FLUSH;
        else if (col_wrap && line_cnt == LINE_LAST)  state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        rd0 = !fifo0_empty;
        rd1 = !fifo1_empty;
        if (flush_done) state_nxt = (start_pend || frame_start) ? S_FILL0 : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign fifo0_wr_en   = wr0;
  assign fifo0_wr_data = pix_in;
  assign fifo0_rd_en   = rd0;
  assign fifo1_rd_en   = rd1;
  assign fifo1_wr_en   = wr_pend;
  // FIFO0 output is valid the cycle after its read, which is when the FIFO1 write fires
  assign fifo1_wr_data = fifo0_rd_data;
  assign busy          = (state != S_IDLE);

  // State, transfer pipeline and pending-start register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_pend    <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_pend <= fwd;
      if (state == S_FLUSH && flush_done)
        start_pend <= 1'b0;
      else if (abort || (state == S_FLUSH && frame_start))
        start_pend <= 1'b1;
    end
  end

  // Column/line counters; the pixel with frame_start in IDLE is already column 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt  <= '0;
      line_cnt <= '0;
    end else if (state == S_IDLE && frame_start) begin
      col_cnt  <= pix_vld ? CNT_W'(1) : '0;
      line_cnt <= '0;
    end else if (state == S_FLUSH && state_nxt == S_FILL0) begin
      col_cnt  <= '0;
      line_cnt <= '0;
    end else if (take) begin
      if (col_wrap) begin
        col_cnt  <= '0;
        line_cnt <= line_cnt + CNT_W'(1);
      end else begin
        col_cnt <= col_cnt + CNT_W'(1);
      end
    end
  end

  // Window taps: tap0 registered, tap1/tap2 captured from FIFO outputs and held between windows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_vld_q <= 1'b0;
      tap0_q    <= 1'b0;
      tap1_q    <= 1'b0;
      tap2_q    <= 1'b0;
    end else begin
      win_vld_q <= stream_take;
      if (stream_take) tap0_q <= pix_in;
      if (win_vld_q) begin
        tap1_q <= fifo0_rd_data;
        tap2_q <= fifo1_rd_data;
      end
    end
  end

  assign win_vld = win_vld_q;
  assign tap0    = tap0_q;
  assign tap1    = win_vld_q ? fifo0_rd_data : tap1_q;
  assign tap2    = win_vld_q ? fifo1_rd_data : tap2_q;

  // Sticky protocol error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf   <= 1'b0;
      err_udf   <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      if ((wr0 && fifo0_full) || (wr_pend && fifo1_full)) err_ovf <= 1'b1;
      if (state != S_FLUSH && ((rd0 && fifo0_empty) || (rd1 && fifo1_empty))) err_udf <= 1'b1;
      if (abort) err_abort <= 1'b1;
    end
  end

endmodule

// File: tb/tb_line_buf_1bit_ctrl.sv
// tb/tb_line_buf_1bit_ctrl.sv - scoreboard bench for line_buf_1bit_ctrl with behavioural FIFOs
module tb_line_buf_1bit_ctrl;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int CW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_start, pix_vld, pix_in;
  logic fifo0_wr_en, fifo0_wr_data, fifo0_rd_en, fifo0_rd_data, fifo0_full, fifo0_empty;
  logic fifo1_wr_en, fifo1_wr_data, fifo1_rd_en, fifo1_rd_data, fifo1_full, fifo1_empty;
  logic win_vld, tap0, tap1, tap2, busy, err_ovf, err_udf, err_abort;
  logic [CW-1:0] col_cnt, line_cnt;

  int checks = 0;
  int failures = 0;
  int win_cnt = 0;
  int cyc = 0;

  bit   q0[$];
  bit   q1[$];
  int   cnt0, cnt1;
  logic rd0d, rd1d;
  logic force_full0, force_empty1;

  bit       pix[W*H];
  logic [2:0] exp_q[$];
  int       exp_cyc_q[$];

  always #5 clk = ~clk;

  line_buf_1bit_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_vld(pix_vld), .pix_in(pix_in),
    .fifo0_wr_en(fifo0_wr_en), .fifo0_wr_data(fifo0_wr_data), .fifo0_rd_en(fifo0_rd_en),
    .fifo0_rd_data(fifo0_rd_data), .fifo0_full(fifo0_full), .fifo0_empty(fifo0_empty),
    .fifo1_wr_en(fifo1_wr_en), .fifo1_wr_data(fifo1_wr_data), .fifo1_rd_en(fifo1_rd_en),
    .fifo1_rd_data(fifo1_rd_data), .fifo1_full(fifo1_full), .fifo1_empty(fifo1_empty),
    .win_vld(win_vld), .tap0(tap0), .tap1(tap1), .tap2(tap2), .col_cnt(col_cnt),
    .line_cnt(line_cnt), .busy(busy), .err_ovf(err_ovf), .err_udf(err_udf), .err_abort(err_abort)
  );

  // Behavioural external FIFOs: read data appears the cycle after rd_en
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      cnt0 <= 0;
      cnt1 <= 0;
      rd0d <= 1'b0;
      rd1d <= 1'b0;
    end else begin
      if (fifo0_rd_en && q0.size() > 0) rd0d <= q0.pop_front();
      if (fifo1_rd_en && q1.size() > 0) rd1d <= q1.pop_front();
      if (fifo0_wr_en) q0.push_back(fifo0_wr_data);
      if (fifo1_wr_en) q1.push_back(fifo1_wr_data);
      cnt0 <= q0.size();
      cnt1 <= q1.size();
    end
  end

  assign fifo0_rd_data = rd0d;
  assign fifo1_rd_data = rd1d;
  assign fifo0_empty   = (cnt0 == 0);
  assign fifo1_empty   = (cnt1 == 0) || force_empty1;
  assign fifo0_full    = (cnt0 >= DEPTH) || force_full0;
  assign fifo1_full    = (cnt1 >= DEPTH);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every window the DUT presents is matched against the next expected one
  always @(negedge clk) begin
    if (rst_n === 1'b1 && win_vld === 1'b1) begin
      win_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL win_unexpected actual=window taps=%b%b%b required=no window", tap0, tap1, tap2);
      end else begin
        logic [2:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("win_taps", {29'd0, tap0, tap1, tap2}, {29'd0, e});
        check("win_latency", cyc, ec);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_flush_done();
    int n = 0;
    while (!(cnt0 == 0 && cnt1 == 0) && n < 200) begin
      step();
      n++;
    end
    check("flush_drain_bound", (n < 200), 1);
    step();
    step();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check("idle_bound", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_win_vld"}, win_vld, 0);
    check({tag, "_taps"}, {tap0, tap1, tap2}, 0);
    check({tag, "_cnts"}, {col_cnt, line_cnt}, 0);
    check({tag, "_enables"}, {fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en}, 0);
    check({tag, "_errs"}, {err_ovf, err_udf, err_abort}, 0);
  endtask

  // mode 0: start in IDLE with pixel 0; 1: pulse start during flush; 2: start already latched
  // stop_kind 1: abort with frame_start at stop_idx; 2: reset at stop_idx
  task automatic run_frame(input int patt, input int bubble, input int mode,
                           input int stop_idx, input int stop_kind, input int force_kind);
    for (int l = 0; l < H; l++)
      for (int c = 0; c < W; c++)
        pix[l*W+c] = (patt == 0) ? bit'((l + c) & 1) : bit'($urandom_range(1));
    for (int idx = 2*W; idx < W*H; idx++)
      if (stop_idx < 0 || idx < stop_idx)
        exp_q.push_back({pix[idx], pix[idx-W], pix[idx-2*W]});
    if (mode == 1) begin
      frame_start = 1'b1;
      pix_vld     = 1'b0;
      step();
      frame_start = 1'b0;
    end
    if (mode >= 1) wait_flush_done();
    for (int idx = 0; idx < W*H; idx++) begin
      if (idx > 0 || mode != 0) begin
        while ($urandom_range(99) < bubble) begin
          pix_vld = 1'b0;
          pix_in  = 1'($urandom_range(1));
          step();
        end
      end
      force_full0  = (force_kind == 1) && (idx < W);
      force_empty1 = (force_kind == 1) && (idx >= 2*W) && (idx < 3*W);
      if (idx == stop_idx && stop_kind == 1) begin
        frame_start = 1'b1;
        pix_vld     = 1'b1;
        pix_in      = 1'($urandom_range(1));
        step();
        frame_start = 1'b0;
        pix_vld     = 1'b0;
        return;
      end
      if (idx == stop_idx && stop_kind == 2) begin
        pix_vld = 1'b1;
        rst_n   = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        #1;
        check_reset_outputs("async_rst");
        pix_vld = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        return;
      end
      frame_start = (mode == 0 && idx == 0);
      pix_vld     = 1'b1;
      pix_in      = pix[idx];
      if (idx >= 2*W) exp_cyc_q.push_back(cyc + 1);
      step();
      frame_start = 1'b0;
    end
    pix_vld      = 1'b0;
    force_full0  = 1'b0;
    force_empty1 = 1'b0;
  endtask

  initial begin
    int w0;
    rst_n        = 1'b0;
    frame_start  = 1'b0;
    pix_vld      = 1'b0;
    pix_in       = 1'b0;
    force_full0  = 1'b0;
    force_empty1 = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Checkerboard frame, continuous pixels
    w0 = win_cnt;
    run_frame(0, 0, 0, -1, 0, 0);
    wait_idle();
    check("s1_win_count", win_cnt - w0, 16);
    check("s1_fifos_empty", {cnt0 == 0, cnt1 == 0}, 2'b11);
    check("s1_errs", {err_ovf, err_udf, err_abort}, 0);

    // Same frame with 50% bubbles
    w0 = win_cnt;
    run_frame(0, 50, 0, -1, 0, 0);
    wait_idle();
    check("s2_win_count", win_cnt - w0, 16);
    check("s2_errs", {err_ovf, err_udf, err_abort}, 0);

    // Back-to-back frames, second start lands in FLUSH
    w0 = win_cnt;
    run_frame(1, 20, 0, -1, 0, 0);
    run_frame(1, 20, 1, -1, 0, 0);
    wait_idle();
    check("s3_win_count", win_cnt - w0, 32);
    check("s3_err_abort", err_abort, 0);
    check("s3_fifos_empty", {cnt0 == 0, cnt1 == 0}, 2'b11);

    // Abort at line 2 col 3, then fresh frame
    w0 = win_cnt;
    run_frame(1, 0, 0, 2*W + 3, 1, 0);
    check("s4_err_abort", err_abort, 1);
    run_frame(1, 0, 2, -1, 0, 0);
    wait_idle();
    check("s4_win_count", win_cnt - w0, 3 + 16);
    check("s4_fifos_empty", {cnt0 == 0, cnt1 == 0}, 2'b11);

    // Forced full/empty flags
    run_frame(0, 0, 0, -1, 0, 1);
    wait_idle();
    step();
    check("s5_err_ovf", err_ovf, 1);
    check("s5_err_udf", err_udf, 1);

    // Reset mid-STREAM, then a clean frame
    run_frame(1, 0, 0, 2*W + 5, 2, 0);
    check("s6_errs_cleared", {err_ovf, err_udf, err_abort}, 0);
    w0 = win_cnt;
    run_frame(0, 0, 0, -1, 0, 0);
    wait_idle();
    check("s6_win_count", win_cnt - w0, 16);
    check("s6_errs", {err_ovf, err_udf, err_abort}, 0);

    step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
